// File: rtl/sargantana_hpdc_mem_rd_arb.sv
// ---------------------------------------------------------------------------
// sargantana_hpdc_mem_rd_arb
//
// Purpose:
//   Merges the read requests of NREQ requesters onto one memory request
//   channel using round-robin arbitration. The response channel is routed
//   back by the source index carried in the top two bits of the 8-bit TID.
//   Each requester may have at most MAX_OUT reads in flight. A read is in
//   flight from its request handshake until its last response beat.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   req_*_i / req_ready_o per-requester request channel (flattened vectors)
//   mem_req_*             merged request channel toward memory
//   mem_resp_*            response channel from memory
//   resp_*_o / resp_ready_i per-requester response channel. The payload is
//                         shared by all requesters; only one valid bit is set.
//   bad_tid_o             sticky flag. It is set by a response whose source
//                         index is out of range, or by a counter underflow.
// ---------------------------------------------------------------------------
module sargantana_hpdc_mem_rd_arb #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 49,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NREQ*8-1:0]        req_len_i,
  input  logic [NREQ*3-1:0]        req_size_i,
  input  logic [NREQ*6-1:0]        req_id_i,

  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [ADDR_W-1:0]        mem_req_addr_o,
  output logic [7:0]               mem_req_len_o,
  output logic [2:0]               mem_req_size_o,
  output logic [7:0]               mem_req_id_o,

  input  logic                     mem_resp_valid_i,
  output logic                     mem_resp_ready_o,
  input  logic [7:0]               mem_resp_id_i,
  input  logic [511:0]             mem_resp_data_i,
  input  logic                     mem_resp_last_i,
  input  logic                     mem_resp_error_i,

  output logic [NREQ-1:0]          resp_valid_o,
  input  logic [NREQ-1:0]          resp_ready_i,
  output logic [5:0]               resp_id_o,
  output logic [511:0]             resp_data_o,
  output logic                     resp_last_o,
  output logic                     resp_error_o,

  output logic                     bad_tid_o
);

  localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);
  localparam logic [2:0] NREQ_L    = 3'(NREQ);
  // Pointer reset value: the first search starts at index 0.
  localparam logic [1:0] PTR_RST   = 2'(NREQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  arb_state_e            state_q;
  logic [1:0]            gnt_q;
  logic [1:0]            ptr_q;
  logic [NREQ-1:0][3:0]  cnt_q;
  logic [NREQ-1:0][3:0]  cnt_d;
  logic                  bad_q;
  logic                  bad_d;

  logic [NREQ-1:0]       elig_s;
  logic [1:0]            pick_s;
  logic                  found_s;
  logic [1:0]            gnt_s;
  logic                  mem_req_valid_s;
  logic                  req_hs_s;

  logic [1:0]            resp_src_s;
  logic                  src_ok_s;
  logic                  sel_ready_s;
  logic                  mem_resp_ready_s;
  logic                  resp_hs_s;

  // Eligibility: the requester is valid and still has outstanding credit.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i] = req_valid_i[i] && (cnt_q[i] < MAX_OUT_L);
    end
  end

  // Round-robin search. It starts just after the last granted index.
  always_comb begin
    int idx;
    found_s = 1'b0;
    pick_s  = 2'd0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found_s && elig_s[idx]) begin
        found_s = 1'b1;
        pick_s  = 2'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // While HOLD is active the locked grant wins, whatever the eligibility is.
  assign gnt_s           = (state_q == HOLD) ? gnt_q : pick_s;
  assign mem_req_valid_s = !rst_i && ((state_q == HOLD) || found_s);
  assign req_hs_s        = mem_req_valid_s && mem_req_ready_i;
  assign mem_req_valid_o = mem_req_valid_s;

  // Request ready goes back to the granted requester only.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = req_hs_s && (gnt_s == 2'(i));
    end
  end

  // Payload mux. The granted index is prepended to the requester id.
  always_comb begin
    mem_req_addr_o = '0;
    mem_req_len_o  = 8'd0;
    mem_req_size_o = 3'd0;
    mem_req_id_o   = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s == 2'(i)) begin
        mem_req_addr_o = req_addr_i[i*ADDR_W +: ADDR_W];
        mem_req_len_o  = req_len_i[i*8 +: 8];
        mem_req_size_o = req_size_i[i*3 +: 3];
        mem_req_id_o   = {gnt_s, req_id_i[i*6 +: 6]};
      end else begin
        mem_req_id_o = mem_req_id_o;
      end
    end
  end

  assign resp_src_s = mem_resp_id_i[7:6];
  assign src_ok_s   = ({1'b0, resp_src_s} < NREQ_L);

  // Ready of the addressed requester. An out-of-range source selects nothing.
  always_comb begin
    sel_ready_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (resp_src_s == 2'(i)) begin
        sel_ready_s = resp_ready_i[i];
      end else begin
        sel_ready_s = sel_ready_s;
      end
    end
  end

  // A response with an out-of-range source is drained. Reset also forces ready.
  assign mem_resp_ready_s = rst_i || !src_ok_s || sel_ready_s;
  assign mem_resp_ready_o = mem_resp_ready_s;
  assign resp_hs_s        = !rst_i && mem_resp_valid_i && mem_resp_ready_s;

  // Route the response valid to exactly one requester.
  always_comb begin
    resp_valid_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid_o[i] = !rst_i && mem_resp_valid_i && src_ok_s && (resp_src_s == 2'(i));
    end
  end

  assign resp_id_o    = mem_resp_id_i[5:0];
  assign resp_data_o  = mem_resp_data_i;
  assign resp_last_o  = mem_resp_last_i;
  assign resp_error_o = mem_resp_error_i;

  // Outstanding counters and the sticky error flag, next state.
  always_comb begin
    logic inc;
    logic dec;
    cnt_d = cnt_q;
    bad_d = bad_q;
    inc   = 1'b0;
    dec   = 1'b0;
    if (resp_hs_s && !src_ok_s) begin
      bad_d = 1'b1;
    end else begin
      bad_d = bad_d;
    end
    for (int i = 0; i < NREQ; i++) begin
      inc = req_hs_s && (gnt_s == 2'(i));
      dec = resp_hs_s && src_ok_s && (resp_src_s == 2'(i)) && mem_resp_last_i;
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (dec && !inc) begin
        // Underflow: the counter saturates at zero and the error is flagged.
        if (cnt_q[i] == 4'd0) begin
          bad_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 4'd1;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Arbiter FSM, round-robin pointer, counters and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bad_q <= bad_d;
      if (req_hs_s) begin
        ptr_q <= gnt_s;
      end
      case (state_q)
        IDLE: begin
          // Lock the grant while the memory side stalls the request.
          if (mem_req_valid_s && !mem_req_ready_i) begin
            state_q <= HOLD;
            gnt_q   <= gnt_s;
          end
        end
        HOLD: begin
          if (mem_req_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bad_tid_o = bad_q;

endmodule

// File: tb/tb_sargantana_hpdc_mem_rd_arb.sv
module tb_sargantana_hpdc_mem_rd_arb;

  localparam int NREQ    = 3;
  localparam int ADDR_W  = 49;
  localparam int MAX_OUT = 4;

  logic                   clk_i;
  logic                   rst_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*ADDR_W-1:0] req_addr_i;
  logic [NREQ*8-1:0]      req_len_i;
  logic [NREQ*3-1:0]      req_size_i;
  logic [NREQ*6-1:0]      req_id_i;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [ADDR_W-1:0]      mem_req_addr_o;
  logic [7:0]             mem_req_len_o;
  logic [2:0]             mem_req_size_o;
  logic [7:0]             mem_req_id_o;
  logic                   mem_resp_valid_i;
  logic                   mem_resp_ready_o;
  logic [7:0]             mem_resp_id_i;
  logic [511:0]           mem_resp_data_i;
  logic                   mem_resp_last_i;
  logic                   mem_resp_error_i;
  logic [NREQ-1:0]        resp_valid_o;
  logic [NREQ-1:0]        resp_ready_i;
  logic [5:0]             resp_id_o;
  logic [511:0]           resp_data_o;
  logic                   resp_last_o;
  logic                   resp_error_o;
  logic                   bad_tid_o;

  int total = 0;
  int bad   = 0;

  sargantana_hpdc_mem_rd_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .req_size_i(req_size_i), .req_id_i(req_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_len_o(mem_req_len_o),
    .mem_req_size_o(mem_req_size_o), .mem_req_id_o(mem_req_id_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_id_i(mem_resp_id_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_last_i(mem_resp_last_i), .mem_resp_error_i(mem_resp_error_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_data_o(resp_data_o), .resp_last_o(resp_last_o), .resp_error_o(resp_error_o),
    .bad_tid_o(bad_tid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] rv;     // req_valid_i
    logic       mrdy;   // mem_req_ready_i
    logic       rspv;   // mem_resp_valid_i
    logic [7:0] rid;    // mem_resp_id_i
    logic       last;   // mem_resp_last_i
    logic [2:0] rrdy;   // resp_ready_i
    logic       e_mv;   // expected mem_req_valid_o
    logic [2:0] e_rr;   // expected req_ready_o
    logic [7:0] e_id;   // expected mem_req_id_o (checked when e_mv)
    logic [2:0] e_rv;   // expected resp_valid_o
    logic       e_mrr;  // expected mem_resp_ready_o
    logic [5:0] e_rid;  // expected resp_id_o
    logic       e_bad;  // expected bad_tid_o
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid_i      = 3'b000;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_id_i    = 8'h00;
    mem_resp_last_i  = 1'b0;
    resp_ready_i     = 3'b000;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    next_cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    // Vectors applied back to back after reset; state carries over between them.
    vecs[0]  = '{3'b111, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b001, 8'h0A, 3'b000, 1'b1, 6'h00, 1'b0};
    vecs[1]  = '{3'b111, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b010, 8'h4B, 3'b000, 1'b1, 6'h00, 1'b0};
    vecs[2]  = '{3'b111, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b100, 8'h8C, 3'b000, 1'b1, 6'h00, 1'b0};
    vecs[3]  = '{3'b111, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b001, 8'h0A, 3'b000, 1'b1, 6'h00, 1'b0};
    vecs[4]  = '{3'b111, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b010, 8'h4B, 3'b000, 1'b1, 6'h00, 1'b0};
    vecs[5]  = '{3'b111, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b100, 8'h8C, 3'b000, 1'b1, 6'h00, 1'b0};
    vecs[6]  = '{3'b000, 1'b1, 1'b1, 8'h85, 1'b1, 3'b011, 1'b0, 3'b000, 8'h00, 3'b100, 1'b0, 6'h05, 1'b0};
    vecs[7]  = '{3'b000, 1'b1, 1'b1, 8'h85, 1'b1, 3'b111, 1'b0, 3'b000, 8'h00, 3'b100, 1'b1, 6'h05, 1'b0};
    vecs[8]  = '{3'b000, 1'b1, 1'b1, 8'h41, 1'b0, 3'b111, 1'b0, 3'b000, 8'h00, 3'b010, 1'b1, 6'h01, 1'b0};
    vecs[9]  = '{3'b000, 1'b1, 1'b1, 8'hC0, 1'b1, 3'b000, 1'b0, 3'b000, 8'h00, 3'b000, 1'b1, 6'h00, 1'b0};
    vecs[10] = '{3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 3'b000, 8'h00, 3'b000, 1'b1, 6'h00, 1'b1};

    for (int i = 0; i < NREQ; i++) begin
      req_addr_i[i*ADDR_W +: ADDR_W] = 49'h1000 + 49'(i);
      req_len_i[i*8 +: 8]            = 8'(i + 1);
      req_size_i[i*3 +: 3]           = 3'(i);
      req_id_i[i*6 +: 6]             = 6'(10 + i);
    end
    mem_resp_data_i  = {8{64'hDEAD_BEEF_0123_4567}};
    mem_resp_error_i = 1'b1;

    // Reset: requests and responses are offered, but the outputs stay quiet.
    rst_i = 1'b1;
    idle_inputs();
    req_valid_i      = 3'b111;
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b1;
    resp_ready_i     = 3'b000;
    next_cycle();
    @(negedge clk_i);
    chk("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_mem_resp_ready", 64'(mem_resp_ready_o), 64'd1);
    chk("rst_bad_tid", 64'(bad_tid_o), 64'd0);
    next_cycle();
    rst_i = 1'b0;

    // Table-driven vectors: round robin 0,1,2,0,1,2 and response routing.
    for (int v = 0; v < 11; v++) begin
      req_valid_i      = vecs[v].rv;
      mem_req_ready_i  = vecs[v].mrdy;
      mem_resp_valid_i = vecs[v].rspv;
      mem_resp_id_i    = vecs[v].rid;
      mem_resp_last_i  = vecs[v].last;
      resp_ready_i     = vecs[v].rrdy;
      @(negedge clk_i);
      chk($sformatf("v%0d_mem_req_valid", v), 64'(mem_req_valid_o), 64'(vecs[v].e_mv));
      chk($sformatf("v%0d_req_ready", v), 64'(req_ready_o), 64'(vecs[v].e_rr));
      if (vecs[v].e_mv) begin
        chk($sformatf("v%0d_mem_req_id", v), 64'(mem_req_id_o), 64'(vecs[v].e_id));
      end
      chk($sformatf("v%0d_resp_valid", v), 64'(resp_valid_o), 64'(vecs[v].e_rv));
      chk($sformatf("v%0d_mem_resp_ready", v), 64'(mem_resp_ready_o), 64'(vecs[v].e_mrr));
      chk($sformatf("v%0d_resp_id", v), 64'(resp_id_o), 64'(vecs[v].e_rid));
      chk($sformatf("v%0d_bad_tid", v), 64'(bad_tid_o), 64'(vecs[v].e_bad));
      next_cycle();
    end
    chk("pass_data", 64'(resp_data_o[127:64]), 64'hDEAD_BEEF_0123_4567);
    chk("pass_error", 64'(resp_error_o), 64'd1);

    // Stall: requester 1 is locked through 5 cycles without ready.
    do_reset();
    @(negedge clk_i);
    chk("post_rst_bad_tid", 64'(bad_tid_o), 64'd0);
    next_cycle();
    req_valid_i     = 3'b010;
    mem_req_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk($sformatf("hold%0d_valid", c), 64'(mem_req_valid_o), 64'd1);
      chk($sformatf("hold%0d_src", c), 64'(mem_req_id_o[7:6]), 64'd1);
      chk($sformatf("hold%0d_addr", c), 64'(mem_req_addr_o), 64'h1001);
      chk($sformatf("hold%0d_len", c), 64'(mem_req_len_o), 64'd2);
      chk($sformatf("hold%0d_req_ready", c), 64'(req_ready_o), 64'd0);
      next_cycle();
      req_valid_i = 3'b011;
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    chk("hold_release_ready", 64'(req_ready_o), 64'b010);
    chk("hold_release_addr", 64'(mem_req_addr_o), 64'h1001);
    next_cycle();
    @(negedge clk_i);
    chk("after_hold_rr", 64'(req_ready_o), 64'b001);
    chk("after_hold_size", 64'(mem_req_size_o), 64'd0);
    next_cycle();

    // Credit limit: 4 outstanding requests block the fifth; one last beat frees it.
    do_reset();
    req_valid_i     = 3'b001;
    mem_req_ready_i = 1'b1;
    resp_ready_i    = 3'b001;
    for (int c = 0; c < MAX_OUT; c++) begin
      @(negedge clk_i);
      chk($sformatf("credit%0d_ready", c), 64'(req_ready_o), 64'b001);
      next_cycle();
    end
    @(negedge clk_i);
    chk("credit_full_valid", 64'(mem_req_valid_o), 64'd0);
    chk("credit_full_ready", 64'(req_ready_o), 64'd0);
    next_cycle();
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = 8'h00;
    mem_resp_last_i  = 1'b1;
    @(negedge clk_i);
    chk("credit_resp_valid", 64'(resp_valid_o), 64'b001);
    chk("credit_resp_blocked", 64'(mem_req_valid_o), 64'd0);
    next_cycle();
    mem_resp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("credit_freed_ready", 64'(req_ready_o), 64'b001);
    chk("credit_freed_bad", 64'(bad_tid_o), 64'd0);
    next_cycle();

    // Underflow: a last beat to an idle requester sets the sticky flag.
    do_reset();
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = 8'h41;
    mem_resp_last_i  = 1'b1;
    resp_ready_i     = 3'b010;
    @(negedge clk_i);
    chk("uflow_before", 64'(bad_tid_o), 64'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    chk("uflow_flag", 64'(bad_tid_o), 64'd1);
    next_cycle();

    // Reset in HOLD with cnt[0]=2: the grant is dropped and the counters clear.
    do_reset();
    req_valid_i     = 3'b001;
    mem_req_ready_i = 1'b1;
    next_cycle();
    next_cycle();
    req_valid_i     = 3'b010;
    mem_req_ready_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_hold_src", 64'(mem_req_id_o[7:6]), 64'd1);
    next_cycle();
    rst_i            = 1'b1;
    req_valid_i      = 3'b011;
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = 8'h00;
    resp_ready_i     = 3'b000;
    @(negedge clk_i);
    chk("midrst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("midrst_req_ready", 64'(req_ready_o), 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("midrst_mem_resp_ready", 64'(mem_resp_ready_o), 64'd1);
    next_cycle();
    rst_i = 1'b0;
    idle_inputs();
    req_valid_i     = 3'b011;
    mem_req_ready_i = 1'b0;
    @(negedge clk_i);
    chk("postrst_grant0", 64'(mem_req_id_o), 64'h0A);
    next_cycle();
    do_reset();
    req_valid_i     = 3'b001;
    mem_req_ready_i = 1'b1;
    for (int c = 0; c < MAX_OUT; c++) begin
      @(negedge clk_i);
      chk($sformatf("postrst_credit%0d", c), 64'(req_ready_o), 64'b001);
      next_cycle();
    end
    @(negedge clk_i);
    chk("postrst_credit_full", 64'(mem_req_valid_o), 64'd0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sargantana_hpdc_mem_rd_arb.md
SARGANTANA_HPDC_MEM_RD_ARB -- requirements
Module: sargantana_hpdc_mem_rd_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 3, number of read requesters (2..4); ADDR_W, default 49, physical address width; MAX_OUT, default 4, max outstanding reads per requester (1..15).
REQ-002 Fixed widths SHALL be: TID 8 bits (bits[7:6] = source index, bits[5:0] = requester id); data 512 bits (8 x 64-bit words).
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 req_valid_i  in  NREQ  per-requester read request valid.
REQ-006 req_ready_o  out  NREQ  per-requester request accepted.
REQ-007 req_addr_i  in  NREQ*ADDR_W  per-requester line address.
REQ-008 req_len_i  in  NREQ*8  per-requester burst length minus one.
REQ-009 req_size_i  in  NREQ*3  per-requester log2 beat bytes.
REQ-010 req_id_i  in  NREQ*6  per-requester transaction id.
REQ-011 mem_req_valid_o / mem_req_ready_i  out/in  1/1  merged request handshake.
REQ-012 mem_req_addr_o, mem_req_len_o, mem_req_size_o, mem_req_id_o  out  ADDR_W/8/3/8  merged request payload.
REQ-013 mem_resp_valid_i / mem_resp_ready_o  in/out  1/1  read response handshake.
REQ-014 mem_resp_id_i, mem_resp_data_i, mem_resp_last_i, mem_resp_error_i  in  8/512/1/1  response payload.
REQ-015 resp_valid_o / resp_ready_i  out/in  NREQ/NREQ  per-requester response handshake.
REQ-016 resp_id_o, resp_data_o, resp_last_o, resp_error_o  out  6/512/1/1  response payload, shared across requesters.
REQ-017 bad_tid_o  out  1  sticky flag: response with source index >= NREQ received.

Function
REQ-018 Requester i SHALL be eligible when req_valid_i[i]=1 and its outstanding counter cnt[i] < MAX_OUT.
REQ-019 Arbitration SHALL be round-robin: priority starts at index ptr+1 mod NREQ, where ptr is the last granted index; ptr SHALL update only on a mem request handshake.
REQ-020 The arbiter SHALL have states IDLE and HOLD: IDLE -> HOLD when mem_req_valid_o=1 and mem_req_ready_i=0; HOLD -> IDLE on handshake.
REQ-021 In HOLD the granted index SHALL stay locked and the payload stable until handshake, regardless of other requesters.
REQ-022 mem_req_valid_o SHALL be combinational: 1 when any requester is eligible (IDLE) or locked (HOLD); zero added latency.
REQ-023 req_ready_o[i] SHALL equal (granted==i) AND mem_req_ready_i; at most one bit set.
REQ-024 mem_req_id_o SHALL be {i[1:0], req_id_i[i]}; addr/len/size SHALL pass from the granted requester unchanged.
REQ-025 cnt[i] SHALL increment on request handshake for i and decrement on response handshake for i with last=1; simultaneous both SHALL leave cnt unchanged.
REQ-026 Response source s = mem_resp_id_i[7:6]; resp_valid_o[s] = mem_resp_valid_i; other resp_valid_o bits = 0; mem_resp_ready_o = resp_ready_i[s].
REQ-027 resp_id_o = mem_resp_id_i[5:0]; data/last/error SHALL pass through combinationally.
REQ-028 If s >= NREQ: mem_resp_ready_o=1, no resp_valid_o asserted, no counter changed, bad_tid_o set next cycle and held until reset.
REQ-029 Counter underflow (last response with cnt=0) SHALL saturate at 0 and set bad_tid_o.
REQ-030 Request and response paths SHALL operate concurrently without interaction except via cnt.

Reset
REQ-031 While rst_i=1 at a clock edge: state=IDLE, ptr=NREQ-1 (first grant to index 0), all cnt=0, bad_tid_o=0.
REQ-032 During reset cycles mem_req_valid_o, req_ready_o, resp_valid_o SHALL be 0 and mem_resp_ready_o SHALL be 1; reset mid-HOLD SHALL drop the locked grant.

Verification
REQ-033 All 3 requesters valid, mem_req_ready_i=1 every cycle -> grants 0,1,2,0,1,2; mem_req_id_o[7:6] = 0,1,2,...
REQ-034 Requester 1 granted, mem_req_ready_i=0 for 5 cycles while requester 0 raises valid -> grant and addr stay on 1 for 5 cycles, handshake on cycle 6, next grant to 2 or 0 per RR.
REQ-035 Requester 0 issues 4 requests (MAX_OUT=4) with no responses -> fifth request not granted; one last-beat response id=0x00 -> next cycle requester 0 eligible again.
REQ-036 Response id=0x85, last=1, resp_ready_i[2]=0 for 3 cycles -> resp_valid_o=3'b100, resp_id_o=5, mem_resp_ready_o=0 until ready, cnt[2] decrements once.
REQ-037 Response id=0xC0 with NREQ=3 -> mem_resp_ready_o=1, resp_valid_o=0, bad_tid_o=1 from next cycle.
REQ-038 Assert rst_i for 1 cycle during HOLD with cnt[0]=2 -> all outputs at reset values, cnt=0, next grant to index 0.
